// File: rtl/sort16_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sort16_seq_ctrl
// Sequencing controller for the 16-input combinational sorting network.
// Collects 16 samples from a valid/ready stream into a parallel register that
// drives the network, waits a programmable settle interval so the network's
// multicycle paths resolve, captures the sorted result and streams it back out
// in ascending order (slot 0 first).
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset; aborts any frame in progress
//   in_valid   producer has a sample
//   in_ready   controller accepts a sample this cycle (FILL only)
//   in_data    sample value
//   net_in     parallel bus to the network, slot k at [(k+1)*WIDTH-1 : k*WIDTH]
//   net_out    sorted network output, slot 0 smallest
//   out_valid  out_data is valid (DRAIN only)
//   out_ready  consumer accepts out_data
//   out_data   sorted sample
//   out_last   marks the final sample of the frame
//   busy       high whenever a frame is in progress
// -----------------------------------------------------------------------------
module sort16_seq_ctrl #(
    parameter int WIDTH  = 3,
    parameter int N      = 16,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [N*WIDTH-1:0]   net_in,
    input  logic [N*WIDTH-1:0]   net_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [3:0] LAST_SLOT   = 4'd15;

    state_e               state_q, state_d;
    logic [3:0]           fill_cnt_q, fill_cnt_d;
    logic [3:0]           settle_cnt_q, settle_cnt_d;
    logic [3:0]           rd_cnt_q, rd_cnt_d;
    logic [N*WIDTH-1:0]   fill_q, fill_d;
    logic [N*WIDTH-1:0]   cap_q, cap_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic [3:0]           rd_next_s;

    assign rd_next_s = rd_cnt_q + 4'd1;

    // Next-state and next-output logic for the FILL/SETTLE/DRAIN sequence.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        settle_cnt_d = settle_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        fill_d       = fill_q;
        cap_d        = cap_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;

        case (state_q)
            ST_FILL: begin
                if (in_valid && in_ready_q) begin
                    fill_d[fill_cnt_q*WIDTH +: WIDTH] = in_data;
                    if (fill_cnt_q == LAST_SLOT) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                        fill_cnt_d   = 4'd0;
                        in_ready_d   = 1'b0;
                    end else begin
                        fill_cnt_d   = fill_cnt_q + 4'd1;
                    end
                end else begin
                    fill_cnt_d = fill_cnt_q;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    // Capture and preload the first sorted slot so out_data is
                    // already valid in the first DRAIN cycle.
                    cap_d       = net_out;
                    rd_cnt_d    = 4'd0;
                    state_d     = ST_DRAIN;
                    out_valid_d = 1'b1;
                    out_data_d  = net_out[WIDTH-1:0];
                    out_last_d  = 1'b0;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (rd_cnt_q == LAST_SLOT) begin
                        state_d     = ST_FILL;
                        rd_cnt_d    = 4'd0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        in_ready_d  = 1'b1;
                    end else begin
                        rd_cnt_d    = rd_next_s;
                        out_data_d  = cap_q[rd_next_s*WIDTH +: WIDTH];
                        out_last_d  = (rd_next_s == LAST_SLOT);
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
            end
            default: begin
                state_d      = ST_FILL;
                fill_cnt_d   = 4'd0;
                settle_cnt_d = 4'd0;
                rd_cnt_d     = 4'd0;
                in_ready_d   = 1'b1;
                out_valid_d  = 1'b0;
                out_data_d   = '0;
                out_last_d   = 1'b0;
            end
        endcase

        // Idle means back in FILL with nothing accepted yet.
        busy_d = !((state_d == ST_FILL) && (fill_cnt_d == 4'd0));
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            fill_cnt_q   <= 4'd0;
            settle_cnt_q <= 4'd0;
            rd_cnt_q     <= 4'd0;
            fill_q       <= '0;
            cap_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            fill_q       <= fill_d;
            cap_q        <= cap_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
        end
    end

    assign net_in    = fill_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule
